// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus widths and responder state encoding
package bus_pkg;

    localparam int BUS_DATA_W  = 32;
    localparam int BUS_BE_W    = 4;
    localparam int BUS_BURST_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WWAIT,
        RFETCH,
        RDATA,
        REND,
        ERROR
    } busState_e;

endpackage

// File: rtl/bus_sram_responder_if.sv
// rtl/bus_sram_responder_if.sv - split address/data transaction bus as seen by one target
interface bus_sram_responder_if;
    import bus_pkg::*;

    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   readNotWriteIn;
    logic                   dataValidIn;
    logic                   busyIn;
    logic                   busErrorIn;
    logic [BUS_DATA_W-1:0]  addressDataIn;
    logic [BUS_BE_W-1:0]    byteEnablesIn;
    logic [BUS_BURST_W-1:0] burstSizeIn;

    logic                   endTransactionOut;
    logic                   dataValidOut;
    logic                   busyOut;
    logic                   busErrorOut;
    logic [BUS_DATA_W-1:0]  addressDataOut;

    modport master (
        output beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        input  endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut
    );

    modport slave (
        input  beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        output endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut
    );

endinterface

// File: rtl/bus_sram_bank.sv
// rtl/bus_sram_bank.sv - single-port synchronous RAM with per-lane writes and registered read
module bus_sram_bank
    import bus_pkg::*;
#(
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    clock,
    input  logic [BUS_BE_W-1:0]     laneWrite,
    input  logic                    readEnable,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [BUS_DATA_W-1:0]   writeData,
    output logic [BUS_DATA_W-1:0]   readData
);

    logic [BUS_DATA_W-1:0] memory [2**ADDRESS_BITS];

    // readData only moves on readEnable so a stalled beat stays on the bus unchanged
    always_ff @(posedge clock) begin
        for (int lane = 0; lane < BUS_BE_W; lane++) begin
            if (laneWrite[lane]) begin
                memory[address][lane*8 +: 8] <= writeData[lane*8 +: 8];
            end
        end
        if (readEnable) begin
            readData <= memory[address];
        end
    end

endmodule

// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - SRAM target decoding a bus window, serving byte-enabled write and streamed read bursts
module bus_sram_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0004_0000,
    parameter int          ADDRESS_BITS = 10,
    parameter int          WRITE_WAIT   = 0
) (
    input logic                 clock,
    input logic                 reset,
    bus_sram_responder_if.slave bus
);

    localparam int              TAG_LSB   = ADDRESS_BITS + 2;
    localparam logic [31:0]     LAST_WORD = 32'((1 << ADDRESS_BITS) - 1);
    localparam logic [1:0]      WAIT_LAST = 2'(WRITE_WAIT - 1);

    busState_e               state, nextState;
    logic [ADDRESS_BITS-1:0] wordAddr, nextWordAddr;
    logic [BUS_BURST_W-1:0]  beatCount, nextBeatCount;
    logic [BUS_BURST_W-1:0]  burstSize, nextBurstSize;
    logic [BUS_BE_W-1:0]     byteEnables, nextByteEnables;
    logic                    writeFull, nextWriteFull;
    logic [1:0]              waitCount, nextWaitCount;

    logic                    windowHit;
    logic                    overrun;
    logic [ADDRESS_BITS-1:0] startWord;
    logic [31:0]             burstLastWord;

    logic                    ramWrite;
    logic                    ramRead;
    logic [ADDRESS_BITS-1:0] ramAddr;
    logic [BUS_DATA_W-1:0]   ramData;

    logic                    endTransaction;
    logic                    dataValid;
    logic                    busy;
    logic                    busError;
    logic [BUS_DATA_W-1:0]   readData;

    logic                    unusedInputs;

    assign windowHit     = bus.beginTransactionIn
                           && (bus.addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    assign startWord     = bus.addressDataIn[TAG_LSB-1:2];
    assign burstLastWord = 32'(startWord) + 32'(bus.burstSizeIn);
    assign overrun       = burstLastWord > LAST_WORD;
    assign unusedInputs  = ^{bus.busErrorIn, bus.addressDataIn[1:0]};

    always_comb begin
        nextState       = state;
        nextWordAddr    = wordAddr;
        nextBeatCount   = beatCount;
        nextBurstSize   = burstSize;
        nextByteEnables = byteEnables;
        nextWriteFull   = writeFull;
        nextWaitCount   = waitCount;
        ramWrite        = 1'b0;
        ramRead         = 1'b0;
        ramAddr         = wordAddr;
        endTransaction  = 1'b0;
        dataValid       = 1'b0;
        busy            = 1'b0;
        busError        = 1'b0;
        readData        = '0;

        case (state)
            IDLE: begin
                if (windowHit) begin
                    nextWordAddr    = startWord;
                    nextBeatCount   = '0;
                    nextBurstSize   = bus.burstSizeIn;
                    nextByteEnables = bus.byteEnablesIn;
                    nextWriteFull   = 1'b0;
                    if (overrun) begin
                        nextState = ERROR;
                    end else if (bus.readNotWriteIn) begin
                        nextState = RFETCH;
                    end else begin
                        nextState = WRITE;
                    end
                end
            end

            WRITE: begin
                if (bus.dataValidIn && !bus.busyIn) begin
                    // beats past the burst length are still handshaken but never stored
                    if (!writeFull) begin
                        ramWrite      = 1'b1;
                        nextWordAddr  = wordAddr + ADDRESS_BITS'(1);
                        nextBeatCount = beatCount + 8'd1;
                        nextWriteFull = (beatCount == burstSize);
                    end
                    if (WRITE_WAIT > 0) begin
                        nextState     = WWAIT;
                        nextWaitCount = '0;
                    end
                end
                if (bus.endTransactionIn) begin
                    nextState = IDLE;
                end
            end

            WWAIT: begin
                busy = 1'b1;
                if (waitCount == WAIT_LAST) begin
                    nextState = WRITE;
                end else begin
                    nextWaitCount = waitCount + 2'd1;
                end
                if (bus.endTransactionIn) begin
                    nextState = IDLE;
                end
            end

            RFETCH: begin
                ramRead   = 1'b1;
                nextState = RDATA;
            end

            RDATA: begin
                dataValid = 1'b1;
                readData  = ramData;
                if (bus.endTransactionIn) begin
                    nextState = IDLE;
                end else if (!bus.busyIn) begin
                    if (beatCount == burstSize) begin
                        nextState = REND;
                    end else begin
                        // prefetch the following word so the next beat lands back-to-back
                        ramRead       = 1'b1;
                        nextWordAddr  = wordAddr + ADDRESS_BITS'(1);
                        ramAddr       = nextWordAddr;
                        nextBeatCount = beatCount + 8'd1;
                    end
                end
            end

            REND: begin
                endTransaction = 1'b1;
                nextState      = IDLE;
            end

            ERROR: begin
                endTransaction = 1'b1;
                busError       = 1'b1;
                nextState      = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wordAddr    <= '0;
            beatCount   <= '0;
            burstSize   <= '0;
            byteEnables <= '0;
            writeFull   <= 1'b0;
            waitCount   <= '0;
        end else begin
            state       <= nextState;
            wordAddr    <= nextWordAddr;
            beatCount   <= nextBeatCount;
            burstSize   <= nextBurstSize;
            byteEnables <= nextByteEnables;
            writeFull   <= nextWriteFull;
            waitCount   <= nextWaitCount;
        end
    end

    bus_sram_bank #(
        .ADDRESS_BITS(ADDRESS_BITS)
    ) bank (
        .clock      (clock),
        .laneWrite  (ramWrite ? byteEnables : '0),
        .readEnable (ramRead),
        .address    (ramAddr),
        .writeData  (bus.addressDataIn),
        .readData   (ramData)
    );

    assign bus.endTransactionOut = endTransaction;
    assign bus.dataValidOut      = dataValid;
    assign bus.busyOut           = busy;
    assign bus.busErrorOut       = busError;
    assign bus.addressDataOut    = readData;

endmodule

// File: tb/tb_bus_sram_responder.sv
// tb/tb_bus_sram_responder.sv - self-checking bench for bus_sram_responder
module tb_bus_sram_responder;
    import bus_pkg::*;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0004_0000;
    localparam int          K_OK   = 0;
    localparam int          K_ERR  = 1;
    localparam int          K_MISS = 2;

    localparam logic [63:0] QUIET     = 64'd0;
    localparam logic [63:0] END_PULSE = {28'd0, 4'b1000, 32'd0};
    localparam logic [63:0] ERR_PULSE = {28'd0, 4'b1001, 32'd0};
    localparam logic [63:0] BUSY_ONLY = {28'd0, 4'b0010, 32'd0};

    typedef struct {
        logic [31:0] addr;
        int          burst;
        bit          rnw;
        int          kind;
    } vector_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        resetN2;
    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wrData [$];
    vector_t     vectors [10];

    int          rBurst;
    int          rStart;
    int          rExtra;
    bit          rRnw;
    logic [31:0] rAddr;

    always #5 clock = ~clock;

    bus_sram_responder_if bus ();
    bus_sram_responder_if bus2 ();

    bus_sram_responder #(
        .BASE_ADDRESS (BASE),
        .ADDRESS_BITS (10),
        .WRITE_WAIT   (0)
    ) dut (
        .clock (clock),
        .reset (resetN),
        .bus   (bus)
    );

    bus_sram_responder #(
        .BASE_ADDRESS (BASE),
        .ADDRESS_BITS (10),
        .WRITE_WAIT   (2)
    ) dutWait (
        .clock (clock),
        .reset (resetN2),
        .bus   (bus2)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic logic [63:0] outs();
        return {28'd0, bus.endTransactionOut, bus.dataValidOut, bus.busyOut, bus.busErrorOut, bus.addressDataOut};
    endfunction

    function automatic logic [63:0] outs2();
        return {28'd0, bus2.endTransactionOut, bus2.dataValidOut, bus2.busyOut, bus2.busErrorOut, bus2.addressDataOut};
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] data);
        return {28'd0, 4'b0100, data};
    endfunction

    task automatic idleInputs();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.readNotWriteIn     = 1'b0;
        bus.dataValidIn        = 1'b0;
        bus.busyIn             = 1'b0;
        bus.busErrorIn         = 1'b0;
        bus.addressDataIn      = 32'd0;
        bus.byteEnablesIn      = 4'd0;
        bus.burstSizeIn        = 8'd0;
    endtask

    task automatic startTransaction(input logic [31:0] addr, input int burst, input bit rnw, input logic [3:0] be);
        @(negedge clock);
        bus.beginTransactionIn = 1'b1;
        bus.readNotWriteIn     = rnw;
        bus.addressDataIn      = addr;
        bus.byteEnablesIn      = be;
        bus.burstSizeIn        = 8'(burst);
        @(negedge clock);
        idleInputs();
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input bit endWithLast, input bit randomStall);
        int start;
        int accepted;
        start    = int'(addr[11:2]);
        accepted = 0;
        startTransaction(addr, burst, 1'b0, be);
        while (accepted < wrData.size()) begin
            check("write busyOut low", {63'd0, bus.busyOut}, 64'd0);
            if (randomStall && $urandom_range(3) == 0) begin
                bus.dataValidIn   = 1'($urandom_range(1));
                bus.busyIn        = 1'b1;
                bus.addressDataIn = $urandom();
            end else begin
                bus.dataValidIn      = 1'b1;
                bus.busyIn           = 1'b0;
                bus.addressDataIn    = wrData[accepted];
                bus.endTransactionIn = endWithLast && (accepted == wrData.size() - 1);
                if (accepted <= burst) begin
                    for (int lane = 0; lane < 4; lane++) begin
                        if (be[lane]) model[start + accepted][8*lane +: 8] = wrData[accepted][8*lane +: 8];
                    end
                end
                accepted++;
            end
            @(negedge clock);
        end
        idleInputs();
        if (!endWithLast) begin
            bus.endTransactionIn = 1'b1;
            @(negedge clock);
            bus.endTransactionIn = 1'b0;
        end
        check("write idle after end", outs(), QUIET);
    endtask

    // stallMode: 0 none, 1 random, 2 hold beat 1 for three busy cycles
    task automatic busRead(input logic [31:0] addr, input int burst, input int stallMode, input int abortAt);
        int start;
        int idx;
        int held;
        start = int'(addr[11:2]);
        idx   = 0;
        held  = 0;
        startTransaction(addr, burst, 1'b1, 4'h0);
        check("read fetch cycle quiet", outs(), QUIET);
        @(negedge clock);
        while (idx <= burst) begin
            check("read beat", outs(), beat(model[start + idx]));
            if (idx == abortAt) begin
                bus.endTransactionIn = 1'b1;
                bus.busyIn           = 1'b0;
                @(negedge clock);
                idleInputs();
                check("read abort quiet", outs(), QUIET);
                return;
            end
            if ((stallMode == 1 && held < 3 && $urandom_range(3) == 0) ||
                (stallMode == 2 && idx == 1 && held < 3)) begin
                bus.busyIn = 1'b1;
                held++;
            end else begin
                bus.busyIn = 1'b0;
                held = 0;
                idx++;
            end
            @(negedge clock);
        end
        bus.busyIn = 1'b0;
        check("read end pulse", outs(), END_PULSE);
        @(negedge clock);
        check("read idle after end", outs(), QUIET);
    endtask

    task automatic errorCheck(input logic [31:0] addr, input int burst, input bit rnw);
        startTransaction(addr, burst, rnw, 4'hF);
        if (!rnw) begin
            bus.dataValidIn   = 1'b1;
            bus.addressDataIn = 32'hDEAD_BEEF;
        end
        check("overrun error pulse", outs(), ERR_PULSE);
        @(negedge clock);
        check("overrun idle after", outs(), QUIET);
        idleInputs();
    endtask

    task automatic missCheck(input logic [31:0] addr, input int burst, input bit rnw);
        startTransaction(addr, burst, rnw, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check("window miss quiet", outs(), QUIET);
            @(negedge clock);
        end
    endtask

    initial begin
        vectors[0] = '{32'h0000_03E8, 0,   1'b1, K_MISS};
        vectors[1] = '{32'h0004_0FFC, 1,   1'b1, K_ERR};
        vectors[2] = '{32'h0004_0FFC, 1,   1'b0, K_ERR};
        vectors[3] = '{32'h0004_0FFC, 0,   1'b1, K_OK};
        vectors[4] = '{32'h0004_0FF8, 1,   1'b1, K_OK};
        vectors[5] = '{32'h0004_0C04, 255, 1'b1, K_ERR};
        vectors[6] = '{32'h0004_0C00, 255, 1'b1, K_OK};
        vectors[7] = '{32'h0004_1000, 0,   1'b1, K_MISS};
        vectors[8] = '{32'h0003_FFFC, 0,   1'b0, K_MISS};
        vectors[9] = '{32'h0004_0003, 1,   1'b1, K_OK};

        resetN  = 1'b0;
        resetN2 = 1'b0;
        idleInputs();
        bus2.beginTransactionIn = 1'b0;
        bus2.endTransactionIn   = 1'b0;
        bus2.readNotWriteIn     = 1'b0;
        bus2.dataValidIn        = 1'b0;
        bus2.busyIn             = 1'b0;
        bus2.busErrorIn         = 1'b0;
        bus2.addressDataIn      = 32'd0;
        bus2.byteEnablesIn      = 4'd0;
        bus2.burstSizeIn        = 8'd0;
        repeat (3) @(negedge clock);
        check("reset outputs", outs(), QUIET);
        check("reset outputs wait variant", outs2(), QUIET);
        resetN  = 1'b1;
        resetN2 = 1'b1;

        for (int b = 0; b < 4; b++) begin
            wrData.delete();
            for (int i = 0; i < 256; i++) wrData.push_back($urandom());
            busWrite(BASE + 32'(b * 1024), 4'hF, 255, b[0], 1'b1);
        end

        wrData = '{32'h0123_4567, 32'h89AB_CDEF, 32'hAABB_5577};
        busWrite(32'h0004_0000, 4'hF, 2, 1'b0, 1'b0);
        busRead(32'h0004_0000, 2, 0, -1);

        wrData = '{32'h0000_0000};
        busWrite(32'h0004_0010, 4'hF, 0, 1'b0, 1'b0);
        wrData = '{32'h6767_6767};
        busWrite(32'h0004_0010, 4'h8, 0, 1'b1, 1'b0);
        busRead(32'h0004_0010, 0, 0, -1);
        check("lane merge result", {32'd0, model[4]}, {32'd0, 32'h6700_0000});

        busRead(32'h0004_0000, 3, 2, -1);

        wrData = '{32'hCAFE_0001, 32'hCAFE_0002};
        busWrite(32'h0004_0040, 4'hF, 3, 1'b1, 1'b0);
        busRead(32'h0004_0040, 3, 0, -1);

        wrData = '{32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98};
        busWrite(32'h0004_0050, 4'h5, 0, 1'b0, 1'b1);
        busRead(32'h0004_0050, 2, 0, -1);

        busRead(32'h0004_0100, 5, 0, 2);

        foreach (vectors[v]) begin
            case (vectors[v].kind)
                K_OK:    busRead(vectors[v].addr, vectors[v].burst, 0, -1);
                K_ERR:   errorCheck(vectors[v].addr, vectors[v].burst, vectors[v].rnw);
                default: missCheck(vectors[v].addr, vectors[v].burst, vectors[v].rnw);
            endcase
        end
        busRead(32'h0004_0FF8, 1, 0, -1);

        for (int t = 0; t < 40; t++) begin
            rBurst = $urandom_range(7);
            rStart = ($urandom_range(3) == 0) ? $urandom_range(1023, 1016) : $urandom_range(1023);
            rAddr  = BASE + 32'(rStart * 4) + 32'($urandom_range(3));
            rRnw   = 1'($urandom_range(1));
            if (rStart + rBurst > DEPTH - 1) begin
                errorCheck(rAddr, rBurst, rRnw);
            end else if (rRnw) begin
                busRead(rAddr, rBurst, 1, ($urandom_range(7) == 0) ? $urandom_range(rBurst) : -1);
            end else begin
                rExtra = ($urandom_range(3) == 0) ? 2 : 0;
                wrData.delete();
                for (int i = 0; i < rBurst + 1 + rExtra; i++) wrData.push_back($urandom());
                busWrite(rAddr, 4'($urandom_range(15)), rBurst, 1'($urandom_range(1)), 1'b1);
            end
        end

        @(negedge clock);
        bus2.beginTransactionIn = 1'b1;
        bus2.readNotWriteIn     = 1'b0;
        bus2.addressDataIn      = 32'h0004_0020;
        bus2.byteEnablesIn      = 4'hF;
        bus2.burstSizeIn        = 8'd1;
        @(negedge clock);
        bus2.beginTransactionIn = 1'b0;
        bus2.byteEnablesIn      = 4'h0;
        bus2.burstSizeIn        = 8'd0;
        bus2.dataValidIn        = 1'b1;
        bus2.addressDataIn      = 32'h1111_2222;
        @(negedge clock);
        bus2.dataValidIn   = 1'b0;
        bus2.addressDataIn = 32'd0;
        check("wait cycle 1 after beat 0", outs2(), BUSY_ONLY);
        @(negedge clock);
        check("wait cycle 2 after beat 0", outs2(), BUSY_ONLY);
        @(negedge clock);
        check("write ready after wait", outs2(), QUIET);
        bus2.dataValidIn   = 1'b1;
        bus2.addressDataIn = 32'h3333_4444;
        @(negedge clock);
        bus2.dataValidIn   = 1'b0;
        bus2.addressDataIn = 32'd0;
        check("wait cycle 1 after beat 1", outs2(), BUSY_ONLY);
        @(negedge clock);
        check("wait cycle 2 after beat 1", outs2(), BUSY_ONLY);
        #1 resetN2 = 1'b0;
        #1 check("async reset drops outputs", outs2(), QUIET);
        @(negedge clock);
        resetN2 = 1'b1;
        @(negedge clock);
        bus2.beginTransactionIn = 1'b1;
        bus2.readNotWriteIn     = 1'b1;
        bus2.addressDataIn      = 32'h0004_0020;
        bus2.burstSizeIn        = 8'd1;
        @(negedge clock);
        bus2.beginTransactionIn = 1'b0;
        bus2.readNotWriteIn     = 1'b0;
        bus2.addressDataIn      = 32'd0;
        bus2.burstSizeIn        = 8'd0;
        check("wait variant fetch quiet", outs2(), QUIET);
        @(negedge clock);
        check("retained beat 0 after reset", outs2(), beat(32'h1111_2222));
        @(negedge clock);
        check("retained beat 1 after reset", outs2(), beat(32'h3333_4444));
        @(negedge clock);
        check("wait variant read end", outs2(), END_PULSE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

On-chip SRAM target for the split address/data transaction bus driven by bus initiators such as the CPU, DMA and bench stimulus. It decodes `beginTransactionIn` against its address window and accepts write bursts into a byte-enabled single-port memory. It returns read bursts with full-rate `dataValidOut` beats and honours the `busyIn` back-pressure handshake. All outputs are zero when not driving, so it can be ORed onto the shared bus beside `sdramController`.

## Interface
- `BASE_ADDRESS`, 32'h0004_0000: byte base of the window; aligned to the window size.
- `ADDRESS_BITS`, 10: word-address width; depth is 2^ADDRESS_BITS 32-bit words.
- `WRITE_WAIT`, 0: `busyOut` cycles inserted after each accepted write beat (0..3).
- `clock`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low; clears all state and outputs.
- `beginTransactionIn`, in, 1: one-cycle transaction start.
- `endTransactionIn`, in, 1: initiator end/abort.
- `readNotWriteIn`, in, 1: 1 = read, sampled with begin.
- `dataValidIn`, in, 1: write beat present.
- `busyIn`, in, 1: combined bus busy.
- `busErrorIn`, in, 1: ignored.
- `addressDataIn`, in, 32: byte address on begin, then write data.
- `byteEnablesIn`, in, 4: lane enables, sampled with begin.
- `burstSizeIn`, in, 8: beats minus 1, sampled with begin.
- `endTransactionOut`, out, 1: read completion or error terminate.
- `dataValidOut`, out, 1: read beat present.
- `busyOut`, out, 1: write wait state.
- `busErrorOut`, out, 1: window overrun.
- `addressDataOut`, out, 32: read data; 0 when `dataValidOut` = 0.

## Operation
- Window hit: `addressDataIn[31:ADDRESS_BITS+2] == BASE_ADDRESS[31:ADDRESS_BITS+2]` while `beginTransactionIn` = 1. A miss is ignored and the block stays IDLE. `beginTransactionIn` outside IDLE is ignored.
- Start word is `addressDataIn[ADDRESS_BITS+1:2]`. Byte offset bits are ignored. The word address increments by 1 per accepted beat.
- Overrun: if start + `burstSizeIn` > 2^ADDRESS_BITS−1, go to ERROR. ERROR drives `busErrorOut` = `endTransactionOut` = 1 for one cycle, then returns to IDLE. Memory is not touched.
- States and transitions:
  - IDLE: hit and read → RFETCH; hit and write → WRITE.
  - WRITE: a beat is accepted when `dataValidIn`·!`busyIn`. Enabled lanes of the current word are written and the word address advances. With `WRITE_WAIT` > 0, go to WWAIT. Accepted beats beyond `burstSizeIn`+1 are dropped. `endTransactionIn` → IDLE.
  - WWAIT: `busyOut` = 1 for `WRITE_WAIT` cycles → WRITE. `endTransactionIn` → IDLE.
  - RFETCH: issue memory read of the start word → RDATA.
  - RDATA: `dataValidOut` = 1 with the memory word; all lanes are returned. Accept on !`busyIn`. On accept, fetch the next word so the next beat follows back-to-back. While `busyIn` = 1, hold the word and address stable. Accepting the last beat → REND. `endTransactionIn` → IDLE (abort, no REND).
  - REND: `endTransactionOut` = 1 for one cycle → IDLE.
- Memory contents are not cleared by reset.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Read latency: begin at cycle T gives the first `dataValidOut` at T+2. Without stall, beat k appears at T+2+k. `endTransactionOut` follows the cycle after the last accept.
- Write: a beat accepted at cycle T is visible to a read started at T+1.
- `endTransactionIn` together with a write beat: the beat is written and the block then goes IDLE.
- Reset asserted mid-burst: outputs drop to 0 asynchronously. A partially written burst keeps the beats already written.
- Beat counter is 8-bit and compared against `burstSizeIn`.

## Structure
- `bus_pkg`:
  - state enum: IDLE, WRITE, WWAIT, RFETCH, RDATA, REND, ERROR.
  - `BUS_DATA_W` = 32, `BUS_BE_W` = 4, `BUS_BURST_W` = 8.
- Sub-module `bus_sram_bank`:
  - single-port synchronous RAM, 2^ADDRESS_BITS × 32.
  - per-lane write enables, registered read output.

## Test plan
- Write burst 0x40000, BE F, burstSize 2, data 01234567/89ABCDEF/AABB5577, then `endTransactionIn`. Read back with burstSize 2 → `dataValidOut` at T+2..T+4 with the same three words; `endTransactionOut` at T+5.
- Write 0x40010, BE 8, data 67676767 over a word preset to 0 → read returns 67000000.
- Read burstSize 3 with `busyIn` forced high on beat 1 for 3 cycles → beat 1 is held stable for 4 cycles; total is 4 beats, none repeated or skipped.
- Begin at 0x40FFC with burstSize 1 → `busErrorOut` and `endTransactionOut` high for one cycle at T+1. Memory is unchanged.
- Begin at 0x3E8 (window miss) → all outputs stay 0.
- `WRITE_WAIT` = 2, write of 2 beats → `busyOut` high for 2 cycles after each beat. Reset pulsed during the second wait → outputs are 0 immediately and the first word is retained.
